// File: rtl/amos_perf_cnt_apb_reader.sv
// amos_perf_cnt_apb_reader
// Drives a perf-counter controller over APB. RESET/START/STOP commands become a
// single APB write of the command mask. DUMP reads counters 0..NUM_CNT-1 one by
// one and hands each value out on a valid/ready sample stream before the next read.
// PSLVERR is collected into a sticky err_o that clears on the next accepted command.
module amos_perf_cnt_apb_reader #(
    parameter int unsigned                APB_ADDR_WIDTH = 12,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int unsigned                NUM_CNT        = 9
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    // command interface
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [1:0]                cmd_op_i,
    input  logic [31:0]               cmd_mask_i,
    // APB initiator
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR,
    // sample stream
    output logic                      sample_valid_o,
    input  logic                      sample_ready_i,
    output logic [31:0]               sample_data_o,
    output logic [3:0]                sample_idx_o,
    output logic                      sample_last_o,
    // status
    output logic                      busy_o,
    output logic                      err_o
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, PUSH} state_t;

    localparam logic [1:0] OP_DUMP  = 2'b11;
    localparam logic [3:0] LAST_IDX = 4'(NUM_CNT - 1);

    state_t                    state_reg, state_next;
    logic [1:0]                op_reg;
    logic [31:0]               mask_reg;
    logic [3:0]                k_reg;
    logic [31:0]               sample_data_reg;
    logic [3:0]                sample_idx_reg;
    logic                      sample_last_reg;
    logic                      err_reg;

    logic [APB_ADDR_WIDTH-1:0] cnt_addr [16];
    logic [APB_ADDR_WIDTH-1:0] wr_addr;
    logic [APB_ADDR_WIDTH-1:0] xfer_addr;
    logic                      cmd_accept;
    logic                      xfer_done;
    logic                      push_done;

    // Counter k lives at BASE+0x0C+4k; the table is sized for the 4-bit index so
    // any k_reg value selects a defined entry.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_cnt_addr
            assign cnt_addr[gi] = BASE_ADDR + APB_ADDR_WIDTH'(12 + 4 * gi);
        end
    endgenerate

    // RESET/START/STOP registers sit at BASE+0x00/0x04/0x08, i.e. 4*op.
    assign wr_addr    = BASE_ADDR + APB_ADDR_WIDTH'({op_reg, 2'b00});
    assign xfer_addr  = (op_reg == OP_DUMP) ? cnt_addr[k_reg] : wr_addr;

    assign cmd_accept = cmd_valid_i && (state_reg == IDLE);
    assign xfer_done  = (state_reg == ACCESS) && PREADY;
    assign push_done  = (state_reg == PUSH) && sample_ready_i;

    assign busy_o         = (state_reg != IDLE);
    assign sample_valid_o = (state_reg == PUSH);
    assign sample_data_o  = sample_data_reg;
    assign sample_idx_o   = sample_idx_reg;
    assign sample_last_o  = sample_last_reg;
    assign err_o          = err_reg;

    // State register; reset drops any in-flight transfer or dump.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and APB/handshake outputs; the bus is parked at zero outside SETUP/ACCESS.
    always_comb begin
        state_next  = state_reg;
        cmd_ready_o = 1'b0;
        PSEL        = 1'b0;
        PENABLE     = 1'b0;
        PWRITE      = 1'b0;
        PADDR       = '0;
        PWDATA      = '0;
        case (state_reg)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                PSEL       = 1'b1;
                PWRITE     = (op_reg != OP_DUMP);
                PADDR      = xfer_addr;
                PWDATA     = (op_reg != OP_DUMP) ? mask_reg : 32'h0;
                state_next = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                PWRITE  = (op_reg != OP_DUMP);
                PADDR   = xfer_addr;
                PWDATA  = (op_reg != OP_DUMP) ? mask_reg : 32'h0;
                if (PREADY) begin
                    state_next = (op_reg == OP_DUMP) ? PUSH : IDLE;
                end
            end
            PUSH: begin
                if (sample_ready_i) begin
                    state_next = sample_last_reg ? IDLE : SETUP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Command latch, counter index, captured sample and sticky slave-error flag.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            op_reg          <= 2'b00;
            mask_reg        <= 32'h0;
            k_reg           <= 4'h0;
            sample_data_reg <= 32'h0;
            sample_idx_reg  <= 4'h0;
            sample_last_reg <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            if (cmd_accept) begin
                op_reg   <= cmd_op_i;
                mask_reg <= cmd_mask_i;
                k_reg    <= 4'h0;
                err_reg  <= 1'b0;
            end
            if (xfer_done) begin
                if (PSLVERR) begin
                    err_reg <= 1'b1;
                end
                if (op_reg == OP_DUMP) begin
                    sample_data_reg <= PRDATA;
                    sample_idx_reg  <= k_reg;
                    sample_last_reg <= (k_reg == LAST_IDX);
                end
            end
            if (push_done && !sample_last_reg) begin
                k_reg <= k_reg + 4'h1;
            end
        end
    end

endmodule

// File: tb/tb_amos_perf_cnt_apb_reader.sv
// Bench for amos_perf_cnt_apb_reader: an APB slave with programmable wait states
// and error response, a sample sink with programmable back-pressure, and a model
// that predicts the APB transfers and samples each accepted command should produce.
`timescale 1ns/1ps
module tb_amos_perf_cnt_apb_reader;

    localparam int            AW   = 12;
    localparam logic [AW-1:0] BASE = 12'h000;
    localparam int            N    = 9;

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_DUMP  = 2'b11;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [1:0]    cmd_op_i;
    logic [31:0]   cmd_mask_i;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [31:0]   PRDATA = 32'h0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;
    logic          sample_valid_o;
    logic          sample_ready_i = 1'b1;
    logic [31:0]   sample_data_o;
    logic [3:0]    sample_idx_o;
    logic          sample_last_o;
    logic          busy_o;
    logic          err_o;

    int errors = 0;
    int checks = 0;

    typedef struct packed {logic [AW-1:0] addr; logic wr; logic [31:0] wdata;} apb_t;
    typedef struct packed {logic [3:0] idx; logic [31:0] data; logic last;} smp_t;
    typedef struct packed {logic [1:0] op; logic [31:0] mask;} cmd_t;

    apb_t apb_log[$];
    smp_t smp_log[$];
    cmd_t exp_cmds[$];

    logic [31:0] cnt_mem [16];
    int  wait_cfg     = 0;
    bit  slverr_cfg   = 0;
    int  stall_idx    = -1;
    int  stall_cycles = 0;
    int  stall_cnt    = 0;
    int  wait_cnt     = 0;
    int  setup_cnt    = 0;

    logic [AW-1:0] setup_addr = '0;
    logic          setup_wr   = 1'b0;
    logic [31:0]   setup_wdata = 32'h0;
    logic [AW-1:0] rd_off;
    logic          prev_valid = 1'b0;
    logic          prev_hs    = 1'b0;
    logic [31:0]   prev_data  = 32'h0;
    logic [3:0]    prev_idx   = 4'h0;
    logic          prev_last  = 1'b0;

    amos_perf_cnt_apb_reader #(
        .APB_ADDR_WIDTH(AW),
        .BASE_ADDR     (BASE),
        .NUM_CNT       (N)
    ) dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_op_i      (cmd_op_i),
        .cmd_mask_i    (cmd_mask_i),
        .PADDR         (PADDR),
        .PWDATA        (PWDATA),
        .PWRITE        (PWRITE),
        .PSEL          (PSEL),
        .PENABLE       (PENABLE),
        .PRDATA        (PRDATA),
        .PREADY        (PREADY),
        .PSLVERR       (PSLVERR),
        .sample_valid_o(sample_valid_o),
        .sample_ready_i(sample_ready_i),
        .sample_data_o (sample_data_o),
        .sample_idx_o  (sample_idx_o),
        .sample_last_o (sample_last_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    always #5 HCLK = ~HCLK;

    // Slave responder, sink back-pressure and bus/stream monitors, all at the falling edge.
    always @(negedge HCLK) begin
        if (PSEL && PENABLE) begin
            if (wait_cnt < wait_cfg) begin
                PREADY = 1'b0;
                wait_cnt++;
            end else begin
                PREADY = 1'b1;
            end
        end else begin
            PREADY   = 1'b0;
            wait_cnt = 0;
        end
        PSLVERR = PREADY && slverr_cfg;
        rd_off  = PADDR - BASE - AW'(12);
        PRDATA  = (PSEL && !PWRITE) ? cnt_mem[rd_off[5:2]] : 32'h0;

        if (sample_valid_o && (int'(sample_idx_o) == stall_idx) && (stall_cnt < stall_cycles)) begin
            sample_ready_i = 1'b0;
            stall_cnt++;
        end else begin
            sample_ready_i = 1'b1;
        end

        if (PSEL && !PENABLE) begin
            setup_cnt++;
            setup_addr  = PADDR;
            setup_wr    = PWRITE;
            setup_wdata = PWDATA;
        end
        if (PSEL && PENABLE) begin
            checks++;
            if (PADDR !== setup_addr || PWRITE !== setup_wr || PWDATA !== setup_wdata) begin
                errors++;
                $display("FAIL access_hold: got addr=%h wr=%b wdata=%h, need addr=%h wr=%b wdata=%h",
                         PADDR, PWRITE, PWDATA, setup_addr, setup_wr, setup_wdata);
            end
            if (PREADY) apb_log.push_back('{addr: PADDR, wr: PWRITE, wdata: PWDATA});
        end
        if (!PSEL) begin
            checks++;
            if (PENABLE !== 1'b0 || PADDR !== '0 || PWDATA !== 32'h0) begin
                errors++;
                $display("FAIL idle_bus: got penable=%b addr=%h wdata=%h, need all zero", PENABLE, PADDR, PWDATA);
            end
        end
        checks++;
        if (PSEL === 1'b1 && sample_valid_o === 1'b1) begin
            errors++;
            $display("FAIL apb_in_push: got psel=1 with sample_valid=1, need psel=0");
        end
        if (prev_valid && !prev_hs && sample_valid_o) begin
            checks++;
            if (sample_data_o !== prev_data || sample_idx_o !== prev_idx || sample_last_o !== prev_last) begin
                errors++;
                $display("FAIL sample_hold: got idx=%0d data=%h last=%b, need idx=%0d data=%h last=%b",
                         sample_idx_o, sample_data_o, sample_last_o, prev_idx, prev_data, prev_last);
            end
        end
        if (sample_valid_o && sample_ready_i)
            smp_log.push_back('{idx: sample_idx_o, data: sample_data_o, last: sample_last_o});
        prev_valid = sample_valid_o;
        prev_hs    = sample_valid_o && sample_ready_i;
        prev_data  = sample_data_o;
        prev_idx   = sample_idx_o;
        prev_last  = sample_last_o;
    end

    // Step to just after the next falling edge, clear of the monitor and the rising edge.
    task automatic tick();
        @(negedge HCLK);
        #1;
    endtask

    task automatic clear_logs();
        apb_log.delete();
        smp_log.delete();
        exp_cmds.delete();
        setup_cnt = 0;
        stall_cnt = 0;
    endtask

    // Present a command and hold it until accepted; returns in the first busy cycle.
    task automatic send_cmd(input logic [1:0] op, input logic [31:0] mask);
        int n = 0;
        tick();
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_mask_i  = mask;
        while (!cmd_ready_o && n < 500) begin
            tick();
            n++;
        end
        checks++;
        if (!cmd_ready_o) begin
            errors++;
            $display("FAIL cmd_accept_timeout: got cmd_ready=0 for %0d cycles, need 1", n);
        end else begin
            exp_cmds.push_back('{op: op, mask: mask});
        end
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy_o && cyc < 2000) begin
            cyc++;
            tick();
        end
        checks++;
        if (busy_o) begin
            errors++;
            $display("FAIL idle_timeout: got busy=1 after %0d cycles, need 0", cyc);
        end
    endtask

    // Expected traffic: a write of the mask to BASE+4*op, or a read of every
    // counter with its value pushed out as a sample and last on the final one.
    task automatic check_logs(input string tag);
        apb_t exp_apb[$];
        smp_t exp_smp[$];
        foreach (exp_cmds[c]) begin
            if (exp_cmds[c].op == OP_DUMP) begin
                for (int k = 0; k < N; k++) begin
                    exp_apb.push_back('{addr: BASE + AW'(12 + 4 * k), wr: 1'b0, wdata: 32'h0});
                    exp_smp.push_back('{idx: 4'(k), data: cnt_mem[k], last: (k == N - 1)});
                end
            end else begin
                exp_apb.push_back('{addr: BASE + AW'(4 * int'(exp_cmds[c].op)), wr: 1'b1, wdata: exp_cmds[c].mask});
            end
        end
        checks++;
        if (apb_log.size() != exp_apb.size() || setup_cnt != exp_apb.size()) begin
            errors++;
            $display("FAIL %s apb_count: got %0d transfers %0d setups, need %0d", tag, apb_log.size(), setup_cnt, exp_apb.size());
        end
        for (int i = 0; i < exp_apb.size() && i < apb_log.size(); i++) begin
            checks++;
            if (apb_log[i] !== exp_apb[i]) begin
                errors++;
                $display("FAIL %s apb[%0d]: got addr=%h wr=%b wdata=%h, need addr=%h wr=%b wdata=%h", tag, i,
                         apb_log[i].addr, apb_log[i].wr, apb_log[i].wdata, exp_apb[i].addr, exp_apb[i].wr, exp_apb[i].wdata);
            end
        end
        checks++;
        if (smp_log.size() != exp_smp.size()) begin
            errors++;
            $display("FAIL %s sample_count: got %0d, need %0d", tag, smp_log.size(), exp_smp.size());
        end
        for (int i = 0; i < exp_smp.size() && i < smp_log.size(); i++) begin
            checks++;
            if (smp_log[i] !== exp_smp[i]) begin
                errors++;
                $display("FAIL %s sample[%0d]: got idx=%0d data=%h last=%b, need idx=%0d data=%h last=%b", tag, i,
                         smp_log[i].idx, smp_log[i].data, smp_log[i].last, exp_smp[i].idx, exp_smp[i].data, exp_smp[i].last);
            end
        end
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got ready=%b busy=%b err=%b, need 1 0 0", cmd_ready_o, busy_o, err_o);
        end
        checks++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || PWRITE !== 1'b0 || PADDR !== '0 || PWDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_apb: got psel=%b pen=%b pwr=%b addr=%h wdata=%h, need all zero",
                     PSEL, PENABLE, PWRITE, PADDR, PWDATA);
        end
        checks++;
        if (sample_valid_o !== 1'b0 || sample_data_o !== 32'h0 || sample_idx_o !== 4'h0 || sample_last_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_sample: got v=%b data=%h idx=%0d last=%b, need all zero",
                     sample_valid_o, sample_data_o, sample_idx_o, sample_last_o);
        end
    endtask

    task automatic test_write_cmd();
        int cyc;
        clear_logs();
        wait_cfg = 0; slverr_cfg = 0; stall_idx = -1;
        send_cmd(OP_START, 32'h1FF);
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PWRITE !== 1'b1 || PADDR !== BASE + AW'(4) || PWDATA !== 32'h1FF) begin
            errors++;
            $display("FAIL write_setup: got psel=%b pen=%b pwr=%b addr=%h wdata=%h, need 1 0 1 %h 000001ff",
                     PSEL, PENABLE, PWRITE, PADDR, PWDATA, BASE + AW'(4));
        end
        tick();
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
            errors++;
            $display("FAIL write_access: got psel=%b pen=%b, need 1 1", PSEL, PENABLE);
        end
        tick();
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL write_latency: got cmd_ready=%b three cycles after accept, need 1", cmd_ready_o);
        end
        wait_idle(cyc);
        check_logs("start");
    endtask

    task automatic test_dump();
        int cyc;
        clear_logs();
        wait_cfg = 0; slverr_cfg = 0; stall_idx = -1;
        for (int k = 0; k < 16; k++) cnt_mem[k] = 32'h100 + 32'(k);
        send_cmd(OP_DUMP, $urandom);
        wait_idle(cyc);
        checks++;
        if (cyc != 3 * N) begin
            errors++;
            $display("FAIL dump_latency: got %0d busy cycles, need %0d", cyc, 3 * N);
        end
        check_logs("dump");
    endtask

    task automatic test_dump_stall();
        int cyc;
        clear_logs();
        for (int k = 0; k < 16; k++) cnt_mem[k] = $urandom;
        wait_cfg = 2; slverr_cfg = 0; stall_idx = 4; stall_cycles = 3;
        send_cmd(OP_DUMP, 32'h0);
        wait_idle(cyc);
        checks++;
        if (cyc != 5 * N + 3) begin
            errors++;
            $display("FAIL stall_latency: got %0d busy cycles, need %0d", cyc, 5 * N + 3);
        end
        check_logs("dump_stall");
        stall_idx = -1;
    endtask

    task automatic test_slverr();
        int cyc;
        clear_logs();
        wait_cfg = 0; slverr_cfg = 1;
        send_cmd(OP_RESET, 32'h3);
        wait_idle(cyc);
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL slverr_set: got err=%b, need 1", err_o);
        end
        check_logs("reset_cmd");
        clear_logs();
        slverr_cfg = 0;
        send_cmd(OP_STOP, 32'h5A);
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL slverr_clear: got err=%b after accept, need 0", err_o);
        end
        wait_idle(cyc);
        check_logs("stop_cmd");
    endtask

    task automatic test_reset_midflight();
        int n = 0;
        int cyc;
        clear_logs();
        for (int k = 0; k < 16; k++) cnt_mem[k] = $urandom;
        wait_cfg = 3; slverr_cfg = 0; stall_idx = -1;
        send_cmd(OP_DUMP, 32'h0);
        while (!(PSEL && PENABLE && PADDR == BASE + AW'(12 + 20)) && n < 500) begin
            tick();
            n++;
        end
        checks++;
        if (!(PSEL && PENABLE)) begin
            errors++;
            $display("FAIL midflight_reach: got no access to counter 5 within %0d cycles, need one", n);
        end
        checks++;
        if (smp_log.size() != 5) begin
            errors++;
            $display("FAIL midflight_samples: got %0d samples before counter 5, need 5", smp_log.size());
        end
        HRESETn = 1'b0;
        #1;
        checks++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || sample_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL midflight_abort: got psel=%b pen=%b sv=%b busy=%b, need all zero",
                     PSEL, PENABLE, sample_valid_o, busy_o);
        end
        tick();
        tick();
        HRESETn = 1'b1;
        tick();
        tick();
        checks++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || sample_idx_o !== 4'h0) begin
            errors++;
            $display("FAIL midflight_release: got ready=%b busy=%b idx=%0d, need 1 0 0", cmd_ready_o, busy_o, sample_idx_o);
        end
        clear_logs();
        wait_cfg = 0;
        send_cmd(OP_DUMP, 32'h0);
        wait_idle(cyc);
        check_logs("dump_after_reset");
    endtask

    task automatic test_cmd_hold();
        logic [1:0]  op;
        logic [31:0] mask;
        int n = 0;
        int cyc;
        bit got = 0;
        clear_logs();
        for (int k = 0; k < 16; k++) cnt_mem[k] = $urandom;
        wait_cfg = 1; slverr_cfg = 0; stall_idx = -1;
        send_cmd(OP_DUMP, 32'h0);
        while (!got && n < 500) begin
            op   = 2'($urandom_range(0, 2));
            mask = $urandom;
            cmd_valid_i = 1'b1;
            cmd_op_i    = op;
            cmd_mask_i  = mask;
            if (cmd_ready_o) begin
                got = 1;
                exp_cmds.push_back('{op: op, mask: mask});
            end else begin
                tick();
                n++;
            end
        end
        tick();
        cmd_valid_i = 1'b0;
        checks++;
        if (!got || n != 4 * N) begin
            errors++;
            $display("FAIL hold_ready: got ready after %0d busy cycles (seen=%0d), need %0d", n, got, 4 * N);
        end
        wait_idle(cyc);
        check_logs("cmd_hold");
    endtask

    task automatic test_random();
        int cyc;
        logic [1:0] op;
        for (int it = 0; it < 8; it++) begin
            clear_logs();
            for (int k = 0; k < 16; k++) cnt_mem[k] = $urandom;
            op           = 2'($urandom_range(0, 3));
            wait_cfg     = $urandom_range(0, 2);
            slverr_cfg   = 1'($urandom_range(0, 1));
            stall_idx    = $urandom_range(0, N - 1);
            stall_cycles = $urandom_range(0, 3);
            send_cmd(op, $urandom);
            wait_idle(cyc);
            check_logs($sformatf("random%0d", it));
            checks++;
            if (err_o !== slverr_cfg) begin
                errors++;
                $display("FAIL random%0d err: got %b, need %b", it, err_o, slverr_cfg);
            end
        end
        stall_idx = -1;
    endtask

    initial begin
        HRESETn     = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_op_i    = 2'b00;
        cmd_mask_i  = 32'h0;
        for (int k = 0; k < 16; k++) cnt_mem[k] = 32'h0;
        repeat (3) tick();
        HRESETn = 1'b1;
        test_reset();
        test_write_cmd();
        test_dump();
        test_dump_stall();
        test_slverr();
        test_reset_midflight();
        test_cmd_hold();
        test_random();
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running at 2ms, need completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/amos_perf_cnt_apb_reader.md
AMOS_PERF_CNT_APB_READER -- requirements
Module: amos_perf_cnt_apb_reader

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, width of PADDR.
REQ-002 SHALL have parameter BASE_ADDR, default 0, APB base address of the perf-counter controller (word aligned).
REQ-003 SHALL have parameter NUM_CNT, default 9, number of counters read by a dump (1..16).
REQ-004 SHALL have port HCLK  input  1  clock; all logic is rising-edge.
REQ-005 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports cmd_valid_i input 1, cmd_ready_o output 1, cmd_op_i input 2 (00 RESET, 01 START, 10 STOP, 11 DUMP), cmd_mask_i input 32 (write data for RESET/START/STOP).
REQ-007 SHALL have APB initiator ports PADDR output APB_ADDR_WIDTH, PWDATA output 32, PWRITE output 1, PSEL output 1, PENABLE output 1, PRDATA input 32, PREADY input 1, PSLVERR input 1.
REQ-008 SHALL have ports sample_valid_o output 1, sample_ready_i input 1, sample_data_o output 32, sample_idx_o output 4, sample_last_o output 1.
REQ-009 SHALL have ports busy_o output 1 (FSM not IDLE) and err_o output 1 (sticky PSLVERR flag).

Function
REQ-010 SHALL implement FSM states IDLE, SETUP, ACCESS, PUSH.
REQ-011 SHALL drive cmd_ready_o=1 only in IDLE; a command is accepted when cmd_valid_i && cmd_ready_o.
REQ-012 SHALL on acceptance latch op and mask, clear err_o, clear counter index to 0, and enter SETUP next cycle.
REQ-013 SHALL map addresses: RESET BASE_ADDR+0x00, START +0x04, STOP +0x08, counter k read at +0x0C+4*k.
REQ-014 SHALL in SETUP drive PSEL=1, PENABLE=0, valid PADDR/PWRITE/PWDATA, then enter ACCESS unconditionally.
REQ-015 SHALL in ACCESS drive PSEL=1, PENABLE=1 with PADDR/PWRITE/PWDATA held identical to SETUP, and stay in ACCESS while PREADY=0.
REQ-016 SHALL for RESET/START/STOP drive PWRITE=1, PWDATA=latched mask; on PREADY=1 return to IDLE.
REQ-017 SHALL for DUMP drive PWRITE=0, PWDATA=0; on PREADY=1 capture PRDATA into sample_data_o, k into sample_idx_o, sample_last_o=(k==NUM_CNT-1), enter PUSH.
REQ-018 SHALL in PUSH hold sample_valid_o=1 and all sample outputs stable until sample_ready_i=1; no APB access occurs in PUSH.
REQ-019 SHALL on PUSH handshake return to IDLE if sample_last_o, else increment k and enter SETUP next cycle.
REQ-020 SHALL drive PSEL=0, PENABLE=0 in IDLE and PUSH; PADDR/PWDATA are don't-care when PSEL=0 but SHALL be 0.
REQ-021 SHALL set err_o when PREADY=1 && PSLVERR=1 in ACCESS; err_o stays set until next accepted command; the transfer completes normally (read data still pushed).
REQ-022 SHALL ignore cmd_op_i/cmd_mask_i changes while busy.
REQ-023 SHALL give minimum latencies: write command accept at cycle T -> SETUP T+1, ACCESS T+2, IDLE T+3 with PREADY=1; DUMP with PREADY and sample_ready_i tied 1 takes 3 cycles per counter.

Reset
REQ-024 SHALL on HRESETn=0 asynchronously force IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, sample_valid_o=0, sample_data_o=0, sample_idx_o=0, sample_last_o=0, busy_o=0, err_o=0, cmd_ready_o=1 after release.
REQ-025 SHALL abandon any in-flight transfer or dump on reset assertion; no state resumes after release.

Verification
REQ-026 START mask 0x1FF, PREADY=1 -> one write, PADDR=BASE+0x04, PWDATA=0x1FF, PSEL/PENABLE 10 then 11, cmd_ready_o high 3 cycles after accept.
REQ-027 DUMP with counters returning 0x100+k, sample_ready_i=1 -> 9 samples idx 0..8, data 0x100..0x108, PADDR 0x0C..0x2C, sample_last_o only on idx 8.
REQ-028 DUMP with PREADY low 2 cycles per access and sample_ready_i low 3 cycles on idx 4 -> ACCESS extended, PADDR stable, sample held, no extra APB traffic, data correct.
REQ-029 RESET mask 0x3 with PSLVERR=1 -> err_o=1 after transfer; next STOP command accepted -> err_o=0.
REQ-030 HRESETn asserted during ACCESS of counter 5 -> PSEL/PENABLE/sample_valid_o 0 immediately; after release cmd_ready_o=1, new DUMP restarts at idx 0.
REQ-031 cmd_valid_i held high with changing op during dump -> not accepted until IDLE; accepted op is value present in IDLE cycle.
